// File: rtl/seven_segment_pkg.sv
// Shared constants for the seven-segment animation block: display modes,
// chase range and the hex font used by the decoder.
package seven_segment_pkg;

  // Display modes selected by ui_in[1:0]
  typedef enum logic [1:0] {
    MODE_COUNT  = 2'd0,
    MODE_CHASE  = 2'd1,
    MODE_DIRECT = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_e;

  // Last segment index of the rotating chase (segments a..f)
  localparam logic [2:0] CHASE_LAST = 3'd5;

  // Hex font, entry k occupies bits [7k+6:7k]; segment bit0 = a .. bit6 = g
  localparam logic [111:0] FONT_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Look up the segment pattern for one hex digit
  function automatic logic [6:0] hex_font(input logic [3:0] value);
    return FONT_TABLE[7*int'(value) +: 7];
  endfunction

endpackage

// File: rtl/seven_segment_fun1_if.sv
// Pin bundle of the seven-segment block: enable, user inputs and outputs.
interface seven_segment_fun1_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  modport master (
    output ena, ui_in, uio_in,
    input  uo_out, uio_out, uio_oe
  );

  modport slave (
    input  ena, ui_in, uio_in,
    output uo_out, uio_out, uio_oe
  );
endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit value to 7-segment pattern (active-high, bit0 = a).
module seg7_hex_decoder
  import seven_segment_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  // Font lookup
  always_comb begin
    seg_o = hex_font(value_i);
  end

endmodule

// File: rtl/seven_segment_fun1.sv
// Seven-segment animation block: prescaled tick drives a hex counter, a
// segment chase and a heartbeat; the selected mode is decoded and registered
// into uo_out. Counters run in the background whatever mode is shown.
module seven_segment_fun1
  import seven_segment_pkg::*;
#(
  parameter int BASE_SHIFT = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,  // synchronous, active-high clear
  seven_segment_fun1_if.slave   bus
);

  localparam int PW = BASE_SHIFT + 7;
  localparam int NW = $clog2(PW + 1);

  logic [PW-1:0] p_q, p_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic          hb_q, hb_d;
  logic [7:0]    uo_q, uo_d;

  logic [PW-1:0] mask_s;
  logic [NW-1:0] n_s;
  logic          tick_s;
  logic [3:0]    nib_s;
  logic [6:0]    font_seg_s;
  logic [6:0]    seg_s;
  logic          dp_s;
  mode_e         mode_s;
  logic          unused_s;

  assign mode_s   = mode_e'(bus.ui_in[1:0]);
  assign dp_s     = bus.ui_in[6] & hb_q;
  assign unused_s = ^bus.uio_in[7:4];

  // Tick period exponent: speed plus the base shift unless in fast mode
  always_comb begin
    if (bus.ui_in[7]) begin
      n_s = NW'(bus.ui_in[4:2]);
    end else begin
      n_s = NW'(bus.ui_in[4:2]) + NW'(BASE_SHIFT);
    end
  end

  // Mask of the low N prescaler bits; N = 0 gives an empty mask (tick every cycle)
  always_comb begin
    mask_s = '0;
    for (int i = 0; i < PW; i++) begin
      if (i < int'(n_s)) begin
        mask_s[i] = 1'b1;
      end else begin
        mask_s[i] = 1'b0;
      end
    end
  end

  assign tick_s = bus.ena & ((p_q & mask_s) == mask_s);

  // Direct mode shows the external nibble, every other use of the font is the counter
  always_comb begin
    if (mode_s == MODE_DIRECT) begin
      nib_s = bus.uio_in[3:0];
    end else begin
      nib_s = cnt_q;
    end
  end

  seg7_hex_decoder u_dec (
    .value_i (nib_s),
    .seg_o   (font_seg_s)
  );

  // Segment pattern for the selected mode
  always_comb begin
    case (mode_s)
      MODE_COUNT:  seg_s = font_seg_s;
      MODE_CHASE:  seg_s = 7'b000_0001 << idx_q;
      MODE_DIRECT: seg_s = font_seg_s;
      MODE_BLINK:  seg_s = hb_q ? 7'h7F : 7'h00;
      default:     seg_s = 7'h00;
    endcase
  end

  // Next-state: prescaler, counters and output load only on enabled cycles
  always_comb begin
    p_d   = p_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    hb_d  = hb_q;
    uo_d  = uo_q;
    if (bus.ena) begin
      p_d  = p_q + PW'(1);
      uo_d = {dp_s, seg_s};
      if (tick_s) begin
        hb_d = ~hb_q;
        if (bus.ui_in[5]) begin
          cnt_d = cnt_q - 4'd1;
          if (idx_q == 3'd0) begin
            idx_d = CHASE_LAST;
          end else begin
            idx_d = idx_q - 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
          if (idx_q >= CHASE_LAST) begin
            idx_d = 3'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end else begin
        hb_d = hb_q;
      end
    end else begin
      uo_d = uo_q;
    end
  end

  // State registers; reset wins over enable
  always_ff @(posedge clk) begin
    if (rst_n) begin
      p_q   <= '0;
      cnt_q <= 4'd0;
      idx_q <= 3'd0;
      hb_q  <= 1'b0;
      uo_q  <= 8'h00;
    end else begin
      p_q   <= p_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      hb_q  <= hb_d;
      uo_q  <= uo_d;
    end
  end

  assign bus.uo_out  = uo_q;
  assign bus.uio_out = 8'h00;
  assign bus.uio_oe  = 8'h00;

endmodule

// File: tb/tb_seven_segment_fun1.sv
// Directed bench for seven_segment_fun1.
module tb_seven_segment_fun1;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seven_segment_fun1_if bus ();

  seven_segment_fun1 #(.BASE_SHIFT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  logic [7:0] font_tb [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  logic [7:0] chase_dn [8] = '{8'h01, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h20};
  logic [7:0] chase_up [7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h01};
  logic [7:0] blink_s2 [12] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF,
                                8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b1;
    bus.ena    = 1'b1;
    bus.ui_in  = 8'h80;
    bus.uio_in = 8'h00;

    // Reset state and constant outputs
    step();
    check_eq("reset_uo", bus.uo_out, 8'h00);
    check_eq("uio_out", bus.uio_out, 8'h00);
    check_eq("uio_oe", bus.uio_oe, 8'h00);
    rst_n = 1'b0;

    // Fast up-count through a full wrap
    for (int i = 0; i < 18; i++) begin
      step();
      check_eq($sformatf("count_up_%0d", i), bus.uo_out, font_tb[i % 16]);
    end

    // Freeze with ena=0 (last shown 06, CNT=2), inputs changing meanwhile
    bus.ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bus.ui_in  = (i % 2 == 0) ? 8'h83 : 8'h80;
      bus.uio_in = 8'(i);
      step();
      check_eq($sformatf("freeze_%0d", i), bus.uo_out, 8'h06);
    end
    bus.ui_in = 8'h80;
    bus.ena   = 1'b1;
    step();
    check_eq("resume_0", bus.uo_out, 8'h5B);
    step();
    check_eq("resume_1", bus.uo_out, 8'h4F);

    // Mid-run one-cycle reset
    rst_n = 1'b1;
    step();
    check_eq("midrun_reset", bus.uo_out, 8'h00);
    rst_n = 1'b0;
    step();
    step();
    step();
    check_eq("after_reset_run", bus.uo_out, 8'h5B);

    // Reset while disabled still clears state
    bus.ena = 1'b0;
    rst_n   = 1'b1;
    step();
    check_eq("reset_disabled", bus.uo_out, 8'h00);
    rst_n = 1'b0;
    step();
    check_eq("reset_disabled_hold", bus.uo_out, 8'h00);
    bus.ena = 1'b1;
    step();
    check_eq("reset_disabled_cnt0", bus.uo_out, 8'h3F);
    step();
    check_eq("reset_disabled_cnt1", bus.uo_out, 8'h06);

    // Down count wraps 0 -> F
    bus.ui_in = 8'hA0;
    do_reset();
    step();
    check_eq("count_dn_0", bus.uo_out, 8'h3F);
    step();
    check_eq("count_dn_F", bus.uo_out, 8'h71);
    step();
    check_eq("count_dn_E", bus.uo_out, 8'h79);

    // Chase downward
    bus.ui_in = 8'hA1;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      check_eq($sformatf("chase_dn_%0d", i), bus.uo_out, chase_dn[i]);
    end

    // Chase upward
    bus.ui_in = 8'h81;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step();
      check_eq($sformatf("chase_up_%0d", i), bus.uo_out, chase_up[i]);
    end

    // Direct display
    bus.ui_in = 8'h02;
    do_reset();
    bus.uio_in = 8'h0B;
    step();
    check_eq("direct_B", bus.uo_out, 8'h7C);
    bus.uio_in = 8'h07;
    step();
    check_eq("direct_7", bus.uo_out, 8'h07);
    bus.uio_in = 8'hF0;
    step();
    check_eq("direct_hi_ignored", bus.uo_out, 8'h3F);
    bus.uio_in = 8'h0E;
    step();
    check_eq("direct_E", bus.uo_out, 8'h79);

    // Blink with dp, every cycle
    bus.ui_in = 8'hC3;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step();
      check_eq($sformatf("blink_s0_%0d", i), bus.uo_out, (i % 2 == 0) ? 8'h00 : 8'hFF);
    end

    // Blink with S=2: four cycles per state
    bus.ui_in = 8'hCB;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step();
      check_eq($sformatf("blink_s2_%0d", i), bus.uo_out, blink_s2[i]);
    end

    // Default speed: first count step after 65536 enabled cycles
    bus.ui_in  = 8'h00;
    bus.uio_in = 8'h00;
    do_reset();
    for (int i = 1; i <= 65537; i++) begin
      step();
      if (i == 1000 || i == 65535 || i == 65536) begin
        check_eq($sformatf("slow_hold_%0d", i), bus.uo_out, 8'h3F);
      end else if (i == 65537) begin
        check_eq("slow_first_step", bus.uo_out, 8'h06);
      end else begin
        checks = checks;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
